adc_cap_mem_ctrl: RTL

Parametrised capture/readout controller for a bank of single-port SRAM macros (memory_inst: CLK, CEB, WEB active-low, A, D, Q, 1-cycle read latency).
- Capture phase: writes one row per valid cycle, NUM_BANK words in parallel at a common address.
- Readout phase: fetches each row and serialises it bank-by-bank over a valid/ready stream.
- Sits between the ADC sample aligner and the packet builder in pktctrl.

---
 rtl/adc_cap_mem_ctrl_if.sv | 38 +++
 rtl/adc_cap_mem_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_cap_mem_ctrl_if.sv
// Capture/readout bus between the ADC aligner, the packet builder and the SRAM bank.
// The master modport is the environment side; the slave modport is the controller.
interface adc_cap_mem_ctrl_if #(
  parameter int NUM_BANK = 96,
  parameter int ADDR_W   = 15,
  parameter int DATA_W   = 9
);
  logic                         cap_start;
  logic                         cap_stop;
  logic [ADDR_W-1:0]            cap_last;
  logic                         cap_valid;
  logic [NUM_BANK*DATA_W-1:0]   cap_data;
  logic                         rd_start;
  logic [DATA_W-1:0]            rd_data;
  logic                         rd_valid;
  logic                         rd_ready;
  logic                         rd_last;
  logic                         cap_done;
  logic [ADDR_W:0]              rows_captured;
  logic                         busy;
  logic [NUM_BANK-1:0]          mem_ceb;
  logic [NUM_BANK-1:0]          mem_web;
  logic [NUM_BANK*ADDR_W-1:0]   mem_addr;
  logic [NUM_BANK*DATA_W-1:0]   mem_d;
  logic [NUM_BANK*DATA_W-1:0]   mem_q;

  modport master (
    output cap_start, cap_stop, cap_last, cap_valid, cap_data, rd_start, rd_ready, mem_q,
    input  rd_data, rd_valid, rd_last, cap_done, rows_captured, busy,
           mem_ceb, mem_web, mem_addr, mem_d
  );

  modport slave (
    input  cap_start, cap_stop, cap_last, cap_valid, cap_data, rd_start, rd_ready, mem_q,
    output rd_data, rd_valid, rd_last, cap_done, rows_captured, busy,
           mem_ceb, mem_web, mem_addr, mem_d
  );
endinterface

// File: rtl/adc_cap_mem_ctrl.sv
// Capture rows of NUM_BANK words into an SRAM bank, then stream them out word by word.
// Optional macro MEM_CAP_WRAP_EN enables circular (pre-trigger) capture.
module adc_cap_mem_ctrl #(
  parameter int NUM_BANK = 96,
  parameter int ADDR_W   = 15,
  parameter int DATA_W   = 9
) (
  input  logic               clk,
  input  logic               rst_n,
  adc_cap_mem_ctrl_if.slave  bus
);
  localparam int BANK_W = (NUM_BANK > 1) ? $clog2(NUM_BANK) : 1;
  localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(NUM_BANK - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, CAP = 2'd1, FETCH = 2'd2, DRAIN = 2'd3} state_t;

  state_t                      r_state, w_state_nxt;
  logic [ADDR_W-1:0]           r_wr_ptr, w_wr_ptr_nxt;
  logic [ADDR_W-1:0]           r_cap_last, w_cap_last_nxt;
  logic [ADDR_W:0]             r_rows, w_rows_nxt;
  logic [ADDR_W-1:0]           r_row, w_row_nxt;
  logic [ADDR_W:0]             r_rows_left, w_rows_left_nxt;
  logic [BANK_W-1:0]           r_bank, w_bank_nxt;
  logic                        r_fetch_wait, w_fetch_wait_nxt;
  logic [NUM_BANK*DATA_W-1:0]  r_hold;
  logic                        w_hold_ld;
  logic                        r_rd_valid, w_rd_valid_nxt;
  logic                        r_rd_last, w_rd_last_nxt;
  logic [DATA_W-1:0]           r_rd_data, w_rd_data_nxt;
  logic                        r_cap_done, w_cap_done_nxt;
  logic                        r_busy;
  logic                        r_mem_ceb, w_mem_ceb_nxt;
  logic                        r_mem_web, w_mem_web_nxt;
  logic [ADDR_W-1:0]           r_mem_addr, w_mem_addr_nxt;
  logic [NUM_BANK*DATA_W-1:0]  r_mem_d, w_mem_d_nxt;

  logic                        w_at_last;
  logic                        w_last_row;
  logic [ADDR_W:0]             w_last_rows;
  logic [ADDR_W:0]             w_wr_rows;
  logic [BANK_W-1:0]           w_bank_inc;
  logic [ADDR_W-1:0]           w_start_row;
  logic [ADDR_W-1:0]           w_row_inc;

  assign w_at_last   = bus.cap_valid && (r_wr_ptr == r_cap_last);
  assign w_last_row  = (r_rows_left == (ADDR_W+1)'(1));
  assign w_last_rows = {1'b0, r_cap_last} + (ADDR_W+1)'(1);
  assign w_wr_rows   = {1'b0, r_wr_ptr} + {{ADDR_W{1'b0}}, bus.cap_valid};
  assign w_bank_inc  = r_bank + BANK_W'(1);

`ifdef MEM_CAP_WRAP_EN
  logic r_wrapped, w_wrapped_nxt;
  // After a wrap the oldest row sits at wr_ptr and the ring closes at cap_last.
  assign w_start_row = r_wrapped ? r_wr_ptr : {ADDR_W{1'b0}};
  assign w_row_inc   = (r_wrapped && (r_row == r_cap_last)) ? {ADDR_W{1'b0}} : r_row + ADDR_W'(1);
`else
  assign w_start_row = {ADDR_W{1'b0}};
  assign w_row_inc   = r_row + ADDR_W'(1);
`endif

  // Next-state and next-output computation for the capture/readout FSM.
  always_comb begin
    w_state_nxt      = r_state;
    w_wr_ptr_nxt     = r_wr_ptr;
    w_cap_last_nxt   = r_cap_last;
    w_rows_nxt       = r_rows;
    w_row_nxt        = r_row;
    w_rows_left_nxt  = r_rows_left;
    w_bank_nxt       = r_bank;
    w_fetch_wait_nxt = r_fetch_wait;
    w_hold_ld        = 1'b0;
    w_rd_valid_nxt   = r_rd_valid;
    w_rd_last_nxt    = r_rd_last;
    w_rd_data_nxt    = r_rd_data;
    w_cap_done_nxt   = 1'b0;
    w_mem_ceb_nxt    = 1'b1;
    w_mem_web_nxt    = 1'b1;
    w_mem_addr_nxt   = r_mem_addr;
    w_mem_d_nxt      = r_mem_d;
`ifdef MEM_CAP_WRAP_EN
    w_wrapped_nxt    = r_wrapped;
`endif
    case (r_state)
      IDLE: begin
        if (bus.cap_start) begin
          w_state_nxt    = CAP;
          w_wr_ptr_nxt   = {ADDR_W{1'b0}};
          w_rows_nxt     = {(ADDR_W+1){1'b0}};
          w_cap_last_nxt = bus.cap_last;
`ifdef MEM_CAP_WRAP_EN
          w_wrapped_nxt  = 1'b0;
`endif
        end else if (bus.rd_start && (r_rows != {(ADDR_W+1){1'b0}})) begin
          w_state_nxt      = FETCH;
          w_row_nxt        = w_start_row;
          w_rows_left_nxt  = r_rows;
          w_bank_nxt       = {BANK_W{1'b0}};
          w_fetch_wait_nxt = 1'b0;
          w_mem_ceb_nxt    = 1'b0;
          w_mem_addr_nxt   = w_start_row;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      CAP: begin
        if (bus.cap_valid) begin
          w_mem_ceb_nxt  = 1'b0;
          w_mem_web_nxt  = 1'b0;
          w_mem_addr_nxt = r_wr_ptr;
          w_mem_d_nxt    = bus.cap_data;
          w_wr_ptr_nxt   = r_wr_ptr + ADDR_W'(1);
        end else begin
          w_wr_ptr_nxt = r_wr_ptr;
        end
`ifdef MEM_CAP_WRAP_EN
        if (w_at_last) begin
          w_wr_ptr_nxt  = {ADDR_W{1'b0}};
          w_wrapped_nxt = 1'b1;
        end else begin
          w_wrapped_nxt = r_wrapped;
        end
        if (bus.cap_stop) begin
          w_state_nxt    = IDLE;
          w_cap_done_nxt = 1'b1;
          w_rows_nxt     = (r_wrapped || w_at_last) ? w_last_rows : w_wr_rows;
        end else begin
          w_state_nxt = CAP;
        end
`else
        if (w_at_last) begin
          w_state_nxt    = IDLE;
          w_cap_done_nxt = 1'b1;
          w_rows_nxt     = w_last_rows;
        end else if (bus.cap_stop) begin
          w_state_nxt    = IDLE;
          w_cap_done_nxt = 1'b1;
          w_rows_nxt     = w_wr_rows;
        end else begin
          w_state_nxt = CAP;
        end
`endif
      end
      FETCH: begin
        // First cycle issues the read; mem_q is captured on the second.
        if (!r_fetch_wait) begin
          w_fetch_wait_nxt = 1'b1;
        end else begin
          w_fetch_wait_nxt = 1'b0;
          w_hold_ld        = 1'b1;
          w_state_nxt      = DRAIN;
          w_rd_valid_nxt   = 1'b1;
          w_rd_data_nxt    = bus.mem_q[DATA_W-1:0];
          w_rd_last_nxt    = w_last_row && (LAST_BANK == {BANK_W{1'b0}});
        end
      end
      DRAIN: begin
        if (r_rd_valid && bus.rd_ready) begin
          if (r_bank == LAST_BANK) begin
            w_rd_valid_nxt = 1'b0;
            w_rd_last_nxt  = 1'b0;
            w_bank_nxt     = {BANK_W{1'b0}};
            if (w_last_row) begin
              w_state_nxt = IDLE;
            end else begin
              w_state_nxt     = FETCH;
              w_row_nxt       = w_row_inc;
              w_rows_left_nxt = r_rows_left - (ADDR_W+1)'(1);
              w_mem_ceb_nxt   = 1'b0;
              w_mem_addr_nxt  = w_row_inc;
            end
          end else begin
            w_bank_nxt    = w_bank_inc;
            w_rd_data_nxt = r_hold[DATA_W*int'(w_bank_inc) +: DATA_W];
            w_rd_last_nxt = w_last_row && (w_bank_inc == LAST_BANK);
          end
        end else begin
          w_bank_nxt = r_bank;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State and registered-output update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_wr_ptr     <= {ADDR_W{1'b0}};
      r_cap_last   <= {ADDR_W{1'b0}};
      r_rows       <= {(ADDR_W+1){1'b0}};
      r_row        <= {ADDR_W{1'b0}};
      r_rows_left  <= {(ADDR_W+1){1'b0}};
      r_bank       <= {BANK_W{1'b0}};
      r_fetch_wait <= 1'b0;
      r_hold       <= {(NUM_BANK*DATA_W){1'b0}};
      r_rd_valid   <= 1'b0;
      r_rd_last    <= 1'b0;
      r_rd_data    <= {DATA_W{1'b0}};
      r_cap_done   <= 1'b0;
      r_busy       <= 1'b0;
      r_mem_ceb    <= 1'b1;
      r_mem_web    <= 1'b1;
      r_mem_addr   <= {ADDR_W{1'b0}};
      r_mem_d      <= {(NUM_BANK*DATA_W){1'b0}};
`ifdef MEM_CAP_WRAP_EN
      r_wrapped    <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_wr_ptr     <= w_wr_ptr_nxt;
      r_cap_last   <= w_cap_last_nxt;
      r_rows       <= w_rows_nxt;
      r_row        <= w_row_nxt;
      r_rows_left  <= w_rows_left_nxt;
      r_bank       <= w_bank_nxt;
      r_fetch_wait <= w_fetch_wait_nxt;
      r_hold       <= w_hold_ld ? bus.mem_q : r_hold;
      r_rd_valid   <= w_rd_valid_nxt;
      r_rd_last    <= w_rd_last_nxt;
      r_rd_data    <= w_rd_data_nxt;
      r_cap_done   <= w_cap_done_nxt;
      r_busy       <= (w_state_nxt != IDLE);
      r_mem_ceb    <= w_mem_ceb_nxt;
      r_mem_web    <= w_mem_web_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_d      <= w_mem_d_nxt;
`ifdef MEM_CAP_WRAP_EN
      r_wrapped    <= w_wrapped_nxt;
`endif
    end
  end

  assign bus.rd_data       = r_rd_data;
  assign bus.rd_valid      = r_rd_valid;
  assign bus.rd_last       = r_rd_last;
  assign bus.cap_done      = r_cap_done;
  assign bus.rows_captured = r_rows;
  assign bus.busy          = r_busy;
  assign bus.mem_ceb       = {NUM_BANK{r_mem_ceb}};
  assign bus.mem_web       = {NUM_BANK{r_mem_web}};
  assign bus.mem_addr      = {NUM_BANK{r_mem_addr}};
  assign bus.mem_d         = r_mem_d;
endmodule
